// File: rtl/mem_seq_pkg.sv
// Shared types for the memory-access sequencer that feeds the MEMORY block.
// Holds the FSM state encoding and the load/store op codes.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LDA   = 3'd1,
        WAIT1 = 3'd2,
        IND   = 3'd3,
        WAIT2 = 3'd4,
        ACC   = 3'd5
    } state_t;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_ST = 1'b1;

endpackage

// File: rtl/mem_seq_if.sv
// Request/response handshake between a requester (master) and the mem_seq sequencer (slave).
interface mem_seq_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();

    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic          req_ind;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_wr, req_ind, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_wr, req_ind, req_addr,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/mem_seq.sv
// Sequencer that turns one load/store request (direct or indirect) into the ordered
// ADDR/wAR/srcA/wM control pattern for MEMORY and returns load data on a response strobe.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_RD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_seq_if.slave      req,
    output logic [AW-1:0] ADDR,
    output logic          wAR,
    output logic          srcA,
    output logic          wM,
    input  logic [DW-1:0] M
);

    localparam bit SLOW_RD = (MEM_RD_LAT == 1);

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic          ind_q;
    logic          ready_q;
    logic          war_q;
    logic          src_q;
    logic          wm_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;

    // A slow memory needs a spare cycle after every AR load whose M is consumed;
    // direct stores never look at M, so they skip straight to ACC.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (req.req_valid && ready_q) begin
                    state_d = LDA;
                end
            end
            LDA: begin
                if (ind_q) begin
                    state_d = SLOW_RD ? WAIT1 : IND;
                end else if (SLOW_RD && (wr_q == OP_LD)) begin
                    state_d = WAIT2;
                end else begin
                    state_d = ACC;
                end
            end
            WAIT1:   state_d = IND;
            IND:     state_d = SLOW_RD ? WAIT2 : ACC;
            WAIT2:   state_d = ACC;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            ind_q       <= 1'b0;
            ready_q     <= 1'b1;
            war_q       <= 1'b0;
            src_q       <= 1'b0;
            wm_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state <= state_d;
            if ((state == IDLE) && req.req_valid && ready_q) begin
                addr_q <= req.req_addr;
                wr_q   <= req.req_wr;
                ind_q  <= req.req_ind;
            end
            ready_q     <= (state_d == IDLE);
            war_q       <= (state_d == LDA) || (state_d == IND);
            src_q       <= (state_d == IND);
            wm_q        <= (state_d == ACC) && (wr_q == OP_ST);
            rsp_valid_q <= (state == ACC);
            if ((state == ACC) && (wr_q == OP_LD)) begin
                rsp_data_q <= M;
            end
        end
    end

    // Gating with rst keeps MEMORY from loading AR or writing while reset is held.
    assign wAR  = war_q & rst;
    assign wM   = wm_q & rst;
    assign srcA = src_q;
    assign ADDR = addr_q;

    assign req.req_ready = ready_q;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_data  = rsp_data_q;

endmodule
